// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO phase-increment word from start to stop,
// holding each word for dwell+1 cycles, in single-ramp, sawtooth or triangle mode.
module nco_sweep_ctrl #(
   parameter int FTW_W   = 12,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [FTW_W-1:0]   f_start,
   input  logic [FTW_W-1:0]   f_stop,
   input  logic [FTW_W-1:0]   f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [FTW_W-1:0]   control,
   output logic               busy,
   output logic               done,
   output logic               dir,
   output logic               cfg_err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [DWELL_W-1:0] cnt, cnt_nxt;
   logic [FTW_W-1:0]   control_nxt;
   logic               dir_nxt, busy_nxt, done_nxt, cfg_err_nxt, cap;

   logic [FTW_W-1:0]   start_r, stop_r, step_r;
   logic [DWELL_W-1:0] dwell_r;
   logic [1:0]         mode_r;

   // Sum carries an extra bit so an overshoot clamps to the limit instead of wrapping.
   function automatic logic [FTW_W-1:0] sat_add(input logic [FTW_W-1:0] a,
                                                input logic [FTW_W-1:0] b,
                                                input logic [FTW_W-1:0] lim);
      logic [FTW_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, lim}) ? lim : sum[FTW_W-1:0];
   endfunction

   function automatic logic [FTW_W-1:0] sat_sub(input logic [FTW_W-1:0] a,
                                                input logic [FTW_W-1:0] b,
                                                input logic [FTW_W-1:0] lim);
      logic [FTW_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      return (diff[FTW_W] || (diff[FTW_W-1:0] < lim)) ? lim : diff[FTW_W-1:0];
   endfunction

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      control_nxt = control;
      dir_nxt     = dir;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      cfg_err_nxt = 1'b0;
      cap         = 1'b0;
      if (abort) begin
         state_nxt   = IDLE;
         control_nxt = '0;
         busy_nxt    = 1'b0;
         dir_nxt     = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if ((f_stop < f_start) || (f_step == '0)) begin
                     cfg_err_nxt = 1'b1;
                  end else begin
                     cap         = 1'b1;
                     state_nxt   = RUN;
                     control_nxt = f_start;
                     cnt_nxt     = dwell;
                     dir_nxt     = 1'b1;
                     busy_nxt    = 1'b1;
                  end
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - DWELL_W'(1);
               end else begin
                  cnt_nxt = dwell_r;
                  if (dir) begin
                     if (control != stop_r) begin
                        control_nxt = sat_add(control, step_r, stop_r);
                     end else begin
                        case (mode_r)
                           2'b01: control_nxt = start_r;
                           2'b10: begin
                              dir_nxt     = 1'b0;
                              control_nxt = sat_sub(control, step_r, start_r);
                           end
                           default: begin
                              state_nxt = IDLE;
                              busy_nxt  = 1'b0;
                              done_nxt  = 1'b1;
                           end
                        endcase
                     end
                  end else if (control != start_r) begin
                     control_nxt = sat_sub(control, step_r, start_r);
                  end else begin
                     dir_nxt     = 1'b1;
                     control_nxt = sat_add(control, step_r, stop_r);
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         control <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dir     <= 1'b1;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         control <= control_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         dir     <= dir_nxt;
         cfg_err <= cfg_err_nxt;
      end
   end

   // Sweep configuration is frozen at launch; later input changes are ignored until the next start.
   always_ff @(posedge clk) begin
      if (cap) begin
         start_r <= f_start;
         stop_r  <= f_stop;
         step_r  <= f_step;
         dwell_r <= dwell;
         mode_r  <= mode;
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: a word-list trace model checked every cycle,
// plus directed sequences with literal expectations.
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;
   localparam int FTW_W   = 12;
   localparam int DWELL_W = 16;
   localparam int LIM     = 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, start, abort;
   logic [1:0]         mode;
   logic [FTW_W-1:0]   f_start, f_stop, f_step;
   logic [DWELL_W-1:0] dwell;
   logic [FTW_W-1:0]   control;
   logic               busy, done, dir, cfg_err;

   nco_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
      .control(control), .busy(busy), .done(done), .dir(dir), .cfg_err(cfg_err)
   );

   typedef struct {int ctl; bit busy; bit dir; bit done;} entry_t;
   entry_t trace[$];

   int m_ctl = 0;
   bit m_busy = 0, m_done = 0, m_dir = 1, m_cfg = 0;
   bit chk_en = 0;
   int n_checks = 0, n_pass = 0;
   int busy_cnt;

   int clamp_exp[4] = '{0, 10, 20, 25};
   int tri_exp[9]   = '{10, 20, 30, 20, 10, 20, 30, 20, 10};
   int tri_dir[9]   = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
   int rep_exp[10]  = '{50, 50, 60, 60, 70, 70, 50, 50, 60, 60};
   int deg_dir[4]   = '{1, 0, 1, 0};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   task automatic push_word(input int w, input bit d, input int reps);
      entry_t e;
      e.ctl = w; e.busy = 1'b1; e.dir = d; e.done = 1'b0;
      for (int k = 0; k < reps; k++) trace.push_back(e);
   endtask

   // Expected per-cycle outputs of a whole sweep, derived from its word list.
   task automatic build_trace(input int s, input int p, input int st, input int d, input int md);
      int v;
      int reps;
      entry_t e;
      reps = d + 1;
      trace.delete();
      v = s;
      push_word(v, 1'b1, reps);
      while (v < p) begin
         v += st; if (v > p) v = p;
         push_word(v, 1'b1, reps);
      end
      if (md == 1) begin
         while (trace.size() < LIM) begin
            v = s;
            push_word(v, 1'b1, reps);
            while (v < p) begin
               v += st; if (v > p) v = p;
               push_word(v, 1'b1, reps);
            end
         end
      end else if (md == 2) begin
         while (trace.size() < LIM) begin
            do begin
               v -= st; if (v < s) v = s;
               push_word(v, 1'b0, reps);
            end while (v > s);
            do begin
               v += st; if (v > p) v = p;
               push_word(v, 1'b1, reps);
            end while (v < p);
         end
      end else begin
         e.ctl = p; e.busy = 1'b0; e.dir = 1'b1; e.done = 1'b1;
         trace.push_back(e);
      end
   endtask

   task automatic pop_model();
      entry_t e;
      if (trace.size() == 0) begin
         n_checks++;
         $display("FAIL model_trace at %0t: got empty trace, expected a pending entry", $time);
      end else begin
         e = trace.pop_front();
         m_ctl = e.ctl; m_busy = e.busy; m_dir = e.dir; m_done = e.done;
      end
   endtask

   always @(posedge clk) begin
      if (reset || abort) begin
         m_ctl = 0; m_busy = 0; m_done = 0; m_dir = 1; m_cfg = 0;
         trace.delete();
      end else if (!m_busy) begin
         m_done = 0; m_cfg = 0;
         if (start) begin
            if ((int'(f_stop) < int'(f_start)) || (f_step == '0)) m_cfg = 1;
            else begin
               build_trace(int'(f_start), int'(f_stop), int'(f_step), int'(dwell),
                           (mode == 2'b01) ? 1 : ((mode == 2'b10) ? 2 : 0));
               pop_model();
            end
         end
      end else begin
         pop_model();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_control", int'(control), m_ctl);
         check("model_busy", int'(busy), int'(m_busy));
         check("model_done", int'(done), int'(m_done));
         check("model_dir", int'(dir), int'(m_dir));
         check("model_cfg_err", int'(cfg_err), int'(m_cfg));
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
      f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_control", int'(control), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_dir", int'(dir), 1);
      check("rst_cfg_err", int'(cfg_err), 0);
      reset = 1'b0;
      @(negedge clk);

      // single ramp 100..130 step 10, dwell 2
      f_start = 100; f_stop = 130; f_step = 10; dwell = 2; mode = 2'b00;
      pulse_start();
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         check("ramp_ctl", int'(control), 100 + 10 * (i / 3));
         busy_cnt += int'(busy);
         @(negedge clk);
      end
      check("ramp_busy_len", busy_cnt, 12);
      check("ramp_done", int'(done), 1);
      check("ramp_busy_off", int'(busy), 0);
      check("ramp_end_ctl", int'(control), 130);

      // back-to-back launch in the done cycle: clamped ramp 0..25
      f_start = 0; f_stop = 25; f_step = 10; dwell = 0; mode = 2'b00;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         check("clamp_ctl", int'(control), clamp_exp[i]);
         @(negedge clk);
      end
      check("clamp_done", int'(done), 1);
      check("clamp_end_ctl", int'(control), 25);
      @(negedge clk);

      // rejected configurations
      f_start = 9; f_stop = 5; f_step = 1;
      pulse_start();
      check("cfg_stop_lt_start", int'(cfg_err), 1);
      check("cfg_busy", int'(busy), 0);
      check("cfg_ctl_kept", int'(control), 25);
      @(negedge clk);
      check("cfg_pulse_len", int'(cfg_err), 0);
      f_start = 10; f_stop = 20; f_step = 0;
      pulse_start();
      check("cfg_step_zero", int'(cfg_err), 1);
      check("cfg_ctl_kept2", int'(control), 25);
      @(negedge clk);

      // triangle 10..30 step 10, dwell 0
      f_start = 10; f_stop = 30; f_step = 10; dwell = 0; mode = 2'b10;
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         check("tri_ctl", int'(control), tri_exp[i]);
         check("tri_dir", int'(dir), tri_dir[i]);
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ctl", int'(control), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_dir", int'(dir), 1);

      // repeating ramp with an ignored start mid-sweep
      f_start = 50; f_stop = 70; f_step = 10; dwell = 1; mode = 2'b01;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         check("rep_ctl", int'(control), rep_exp[i]);
         @(negedge clk);
      end
      f_start = 200; f_stop = 300; f_step = 1; dwell = 5; mode = 2'b00;
      pulse_start();
      for (int i = 4; i < 10; i++) begin
         check("rep_ctl_after_start", int'(control), rep_exp[i]);
         check("rep_busy", int'(busy), 1);
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("rep_abort_ctl", int'(control), 0);
      check("rep_abort_busy", int'(busy), 0);
      check("rep_abort_done", int'(done), 0);

      // start and abort together in IDLE
      f_start = 5; f_stop = 15; f_step = 5; dwell = 0; mode = 2'b00;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("sa_busy", int'(busy), 0);
      check("sa_ctl", int'(control), 0);
      @(negedge clk);
      check("sa_busy_later", int'(busy), 0);

      // degenerate triangle, then reset mid-sweep
      f_start = 40; f_stop = 40; f_step = 5; dwell = 0; mode = 2'b10;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         check("deg_ctl", int'(control), 40);
         check("deg_dir", int'(dir), deg_dir[i]);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_ctl", int'(control), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_dir", int'(dir), 1);
      check("mid_rst_cfg", int'(cfg_err), 0);

      // mode 11 behaves as single ramp; start==stop gives one dwell period
      f_start = 7; f_stop = 7; f_step = 1; dwell = 1; mode = 2'b11;
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         check("m3_ctl", int'(control), 7);
         check("m3_busy", int'(busy), 1);
         @(negedge clk);
      end
      check("m3_done", int'(done), 1);
      check("m3_busy_off", int'(busy), 0);
      @(negedge clk);
      check("m3_done_len", int'(done), 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
